// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus arbiter types and widths
// Purpose: FSM state encoding and serial bus widths shared by the arbiter
//          and the slave in-port.
// Ports:   none (package).
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT1   = 2'd1,
    GRANT2   = 2'd2,
    HANDOVER = 2'd3
  } arb_state_t;

  localparam int SLAVE_ID_W = 2;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 8;

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational two-way round-robin winner select
// Purpose: picks which master wins the bus this cycle.
// Ports:
//   req1, req2   in  - requests from M1 / M2
//   last         in  - master granted last (0 = M1, 1 = M2)
//   winner_valid out - at least one request present
//   winner_id    out - winning master (0 = M1, 1 = M2)
module arb_rr_pick (
  input  logic req1,
  input  logic req2,
  input  logic last,
  output logic winner_valid,
  output logic winner_id
);

  assign winner_valid = req1 | req2;
  // On a tie the master that did not own the bus last goes first.
  assign winner_id    = (req1 & req2) ? ~last : req2;

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master / multi-slave serial bus arbiter and router
// Purpose: round-robin grant of the serial lines to M1 or M2, latches the
//          winner's target slave and routes valid/ready between them.
//          Optional grant watchdog enabled by macro BUS_ARB_TIMEOUT_EN.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   m1_req, m2_req          - bus requests, held for the whole transaction
//   m1_slave_sel, m2_slave_sel - target slave ids
//   m1_valid, m2_valid      - master_valid from each master
//   m1_grant, m2_grant      - registered grants
//   m1_ready, m2_ready      - routed slave_ready to the granted master
//   s_valid                 - routed master_valid, one bit per slave
//   s_ready                 - slave_ready from each slave
//   bus_sel                 - serial mux select (0 = M1, 1 = M2)
//   bus_busy                - a grant is active
//   sel_err                 - pulse: request refused for invalid slave id
//   timeout                 - pulse: watchdog revoked a grant
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES     = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m1_req,
  input  logic                  m2_req,
  input  logic [SLAVE_ID_W-1:0] m1_slave_sel,
  input  logic [SLAVE_ID_W-1:0] m2_slave_sel,
  input  logic                  m1_valid,
  input  logic                  m2_valid,
  output logic                  m1_grant,
  output logic                  m2_grant,
  output logic                  m1_ready,
  output logic                  m2_ready,
  output logic [NUM_SLAVES-1:0] s_valid,
  input  logic [NUM_SLAVES-1:0] s_ready,
  output logic                  bus_sel,
  output logic                  bus_busy,
  output logic                  sel_err,
  output logic                  timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES out of range 2..255");
  end

  arb_state_t            state;
  logic [SLAVE_ID_W-1:0] tgt;
  logic                  last;     // 0 = M1 granted last, 1 = M2
  logic                  req1_eff;
  logic                  req2_eff;
  logic                  win_valid;
  logic                  win_id;
  logic [SLAVE_ID_W-1:0] win_sel;
  logic                  win_sel_ok;

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] cnt;
  logic       lockout1;
  logic       lockout2;
  // A revoked master may not compete again until it has released req.
  assign req1_eff = m1_req & ~lockout1;
  assign req2_eff = m2_req & ~lockout2;
`else
  assign req1_eff = m1_req;
  assign req2_eff = m2_req;
  assign timeout  = 1'b0;
`endif

  arb_rr_pick u_pick (
    .req1         (req1_eff),
    .req2         (req2_eff),
    .last         (last),
    .winner_valid (win_valid),
    .winner_id    (win_id)
  );

  assign win_sel    = win_id ? m2_slave_sel : m1_slave_sel;
  assign win_sel_ok = int'(win_sel) < NUM_SLAVES;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tgt      <= '0;
      last     <= 1'b1;
      m1_grant <= 1'b0;
      m2_grant <= 1'b0;
      bus_sel  <= 1'b0;
      bus_busy <= 1'b0;
      sel_err  <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      timeout  <= 1'b0;
      cnt      <= '0;
      lockout1 <= 1'b0;
      lockout2 <= 1'b0;
`endif
    end else begin
      sel_err <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      timeout <= 1'b0;
      if (!m1_req) lockout1 <= 1'b0;
      if (!m2_req) lockout2 <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win_valid) begin
            // A refused request still counts as a turn, so the other
            // master wins the next tie.
            last <= win_id;
            if (win_sel_ok) begin
              state    <= win_id ? GRANT2 : GRANT1;
              tgt      <= win_sel;
              m1_grant <= ~win_id;
              m2_grant <= win_id;
              bus_sel  <= win_id;
              bus_busy <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
              cnt      <= '0;
`endif
            end else begin
              sel_err <= 1'b1;
            end
          end
        end
        GRANT1, GRANT2: begin
          if (!(state == GRANT1 ? m1_req : m2_req)) begin
            state    <= HANDOVER;
            m1_grant <= 1'b0;
            m2_grant <= 1'b0;
            bus_busy <= 1'b0;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            state    <= HANDOVER;
            m1_grant <= 1'b0;
            m2_grant <= 1'b0;
            bus_busy <= 1'b0;
            timeout  <= 1'b1;
            if (state == GRANT1) lockout1 <= 1'b1;
            else                 lockout2 <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        HANDOVER: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Routing is combinational through the latched target so valid and
  // ready reach their destination in the same cycle.
  always_comb begin
    s_valid  = '0;
    m1_ready = 1'b0;
    m2_ready = 1'b0;
    case (state)
      GRANT1: begin
        s_valid[tgt] = m1_valid;
        m1_ready     = s_ready[tgt];
      end
      GRANT2: begin
        s_valid[tgt] = m2_valid;
        m2_ready     = s_ready[tgt];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed scoreboard bench for bus_arbiter
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m1_req = 1'b0, m2_req = 1'b0;
  logic [1:0] m1_slave_sel = 2'd0, m2_slave_sel = 2'd0;
  logic       m1_valid = 1'b0, m2_valid = 1'b0;
  logic       m1_grant, m2_grant, m1_ready, m2_ready;
  logic [2:0] s_valid;
  logic [2:0] s_ready = 3'b000;
  logic       bus_sel, bus_busy, sel_err, timeout;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [10:0] val;
  } exp_t;

  exp_t sb[$];

  bus_arbiter #(.NUM_SLAVES(3), .TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .m1_req       (m1_req),
    .m2_req       (m2_req),
    .m1_slave_sel (m1_slave_sel),
    .m2_slave_sel (m2_slave_sel),
    .m1_valid     (m1_valid),
    .m2_valid     (m2_valid),
    .m1_grant     (m1_grant),
    .m2_grant     (m2_grant),
    .m1_ready     (m1_ready),
    .m2_ready     (m2_ready),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .bus_sel      (bus_sel),
    .bus_busy     (bus_busy),
    .sel_err      (sel_err),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  // Expected output word: {g1, g2, r1, r2, s_valid[2:0], bus_sel, bus_busy, sel_err, timeout}
  function automatic logic [10:0] ex(input logic g1, input logic g2, input logic r1,
                                     input logic r2, input logic [2:0] sv, input logic bs,
                                     input logic bb, input logic se, input logic to);
    return {g1, g2, r1, r2, sv, bs, bb, se, to};
  endfunction

  // One clock: drive inputs just after the edge, queue the expected outputs
  // for this cycle, then compare on the falling edge.
  task automatic cyc(input string tag, input logic rst,
                     input logic r1, input logic [1:0] s1, input logic v1,
                     input logic r2, input logic [1:0] s2, input logic v2,
                     input logic [2:0] sr, input logic [10:0] e);
    exp_t x;
    logic [10:0] obs;
    @(posedge clk);
    #1;
    reset = rst;
    m1_req = r1; m1_slave_sel = s1; m1_valid = v1;
    m2_req = r2; m2_slave_sel = s2; m2_valid = v2;
    s_ready = sr;
    x.tag = tag;
    x.val = e;
    sb.push_back(x);
    @(negedge clk);
    x = sb.pop_front();
    obs = {m1_grant, m2_grant, m1_ready, m2_ready, s_valid, bus_sel, bus_busy, sel_err, timeout};
    checks++;
    assert (obs === x.val) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", x.tag, obs, x.val);
    end
  endtask

  localparam logic [10:0] Z = 11'b0;

  initial begin
    // reset state
    cyc("reset",        1, 0,0,0, 0,0,0, 3'b000, Z);
    // single M1 to slave 2
    cyc("req1_idle",    0, 1,2,0, 0,0,0, 3'b000, Z);
    cyc("m1_grant_s2",  0, 1,2,1, 0,0,0, 3'b100, ex(1,0,1,0,3'b100,0,1,0,0));
    cyc("m1_valid_low", 0, 1,2,0, 0,0,0, 3'b000, ex(1,0,0,0,3'b000,0,1,0,0));
    cyc("m1_hold",      0, 0,2,0, 0,0,0, 3'b000, ex(1,0,0,0,3'b000,0,1,0,0));
    cyc("handover1",    0, 0,0,0, 0,0,0, 3'b000, Z);
    cyc("idle1",        0, 0,0,0, 0,0,0, 3'b000, Z);
    // tie after reset, back-to-back handover
    cyc("rst_tie",      1, 0,0,0, 0,0,0, 3'b000, Z);
    cyc("tie_drive",    0, 1,0,0, 1,1,0, 3'b000, Z);
    cyc("tie_m1",       0, 1,0,1, 1,1,0, 3'b001, ex(1,0,1,0,3'b001,0,1,0,0));
    cyc("m1_fall",      0, 0,0,0, 1,1,0, 3'b000, ex(1,0,0,0,3'b000,0,1,0,0));
    cyc("ho2",          0, 0,0,0, 1,1,0, 3'b000, Z);
    cyc("idle2",        0, 0,0,0, 1,1,0, 3'b000, Z);
    cyc("m2_grant_3cyc",0, 0,0,1, 1,1,1, 3'b010, ex(0,1,0,1,3'b010,1,1,0,0));
    cyc("m2_fall",      0, 0,0,0, 0,1,0, 3'b000, ex(0,1,0,0,3'b000,1,1,0,0));
    cyc("ho3_sel_hold", 0, 0,0,0, 0,0,0, 3'b000, ex(0,0,0,0,3'b000,1,0,0,0));
    cyc("idle3",        0, 0,0,0, 0,0,0, 3'b000, ex(0,0,0,0,3'b000,1,0,0,0));
    // invalid target
    cyc("inv_drive",    0, 0,0,0, 1,3,0, 3'b000, ex(0,0,0,0,3'b000,1,0,0,0));
    cyc("sel_err",      0, 1,0,0, 1,3,0, 3'b000, ex(0,0,0,0,3'b000,1,0,1,0));
    cyc("inv_then_m1",  0, 1,0,1, 1,3,0, 3'b001, ex(1,0,1,0,3'b001,0,1,0,0));
    // slave_sel change during grant
    cyc("sel_change",   0, 1,1,1, 0,0,0, 3'b011, ex(1,0,1,0,3'b001,0,1,0,0));
    cyc("sel_chg_rdy",  0, 1,1,1, 0,0,0, 3'b010, ex(1,0,0,0,3'b001,0,1,0,0));
    cyc("sel_release",  0, 0,1,0, 0,0,0, 3'b000, ex(1,0,0,0,3'b000,0,1,0,0));
    cyc("ho4",          0, 0,0,0, 0,0,0, 3'b000, Z);
    cyc("idle4",        0, 0,0,0, 0,0,0, 3'b000, Z);
    // reset mid-grant
    cyc("pre_g2",       0, 0,0,0, 1,2,0, 3'b000, Z);
    cyc("g2",           0, 0,0,0, 1,2,1, 3'b100, ex(0,1,0,1,3'b100,1,1,0,0));
    cyc("g2_rst_drv",   1, 1,1,0, 1,2,1, 3'b100, ex(0,1,0,1,3'b100,1,1,0,0));
    cyc("rst_mid",      0, 1,1,1, 1,2,1, 3'b111, Z);
    cyc("rst_m1_wins",  0, 1,1,1, 1,2,1, 3'b111, ex(1,0,1,0,3'b010,0,1,0,0));
    cyc("final_fall",   0, 0,0,0, 0,0,0, 3'b000, ex(1,0,0,0,3'b000,0,1,0,0));
    cyc("ho5",          0, 0,0,0, 0,0,0, 3'b000, Z);
    cyc("idle5",        0, 0,0,0, 0,0,0, 3'b000, Z);
`ifdef BUS_ARB_TIMEOUT_EN
    // watchdog: 4 grant cycles, then revoke and lockout until req toggles
    cyc("to_drive",     0, 1,0,0, 0,0,0, 3'b000, Z);
    cyc("to_g1",        0, 1,0,0, 0,0,0, 3'b000, ex(1,0,0,0,3'b000,0,1,0,0));
    cyc("to_g2",        0, 1,0,0, 0,0,0, 3'b000, ex(1,0,0,0,3'b000,0,1,0,0));
    cyc("to_g3",        0, 1,0,0, 0,0,0, 3'b000, ex(1,0,0,0,3'b000,0,1,0,0));
    cyc("to_g4",        0, 1,0,0, 0,0,0, 3'b000, ex(1,0,0,0,3'b000,0,1,0,0));
    cyc("to_pulse",     0, 1,0,0, 0,0,0, 3'b000, ex(0,0,0,0,3'b000,0,0,0,1));
    cyc("to_locked1",   0, 1,0,0, 0,0,0, 3'b000, Z);
    cyc("to_locked2",   0, 0,0,0, 0,0,0, 3'b000, Z);
    cyc("to_unlock",    0, 1,0,0, 0,0,0, 3'b000, Z);
    cyc("to_regrant",   0, 1,0,0, 0,0,0, 3'b000, ex(1,0,0,0,3'b000,0,1,0,0));
`endif
    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, three-slave arbiter and router for the serial system bus. It grants the shared serial address/data lines to one master at a time using round-robin priority. It latches the granted master's target slave and routes that master's `master_valid` / `slave_ready` handshake between the master and the selected slave in-port. It sits between the master out-ports and the slave in-ports and owns the `bus_sel` control of the serial-line mux.

## Interface
Parameters:
- `NUM_SLAVES`, 3 — slave ports; slave ids 0..NUM_SLAVES-1 are valid.
- `TIMEOUT_CYCLES`, 64 — grant watchdog limit in cycles. Used only with `BUS_ARB_TIMEOUT_EN`; range 2..255.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — synchronous, active-high.
- `m1_req`, `m2_req`  in  1 each — bus request, held high for the whole transaction.
- `m1_slave_sel`, `m2_slave_sel`  in  2 each — target slave id; must be stable while req is high.
- `m1_valid`, `m2_valid`  in  1 each — master_valid from each master.
- `m1_grant`, `m2_grant`  out  1 each — registered grants, at most one high.
- `m1_ready`, `m2_ready`  out  1 each — routed slave_ready back to the granted master.
- `s_valid`  out  NUM_SLAVES — routed master_valid, at most one bit high.
- `s_ready`  in  NUM_SLAVES — slave_ready from each slave in-port.
- `bus_sel`  out  1 — serial-line mux select: 0 = M1 drives, 1 = M2 drives.
- `bus_busy`  out  1 — a grant is active.
- `sel_err`  out  1 — one-cycle pulse: a grant was refused for an invalid slave id.
- `timeout`  out  1 — one-cycle pulse: watchdog revoked a grant.

## Operation
- State machine states: IDLE, GRANT1, GRANT2, HANDOVER.
- **IDLE:** if any req is high, select the winner.
  - Only one req high: that master wins.
  - Both high: the master not granted last wins. `last` resets to M2, so M1 wins the first tie.
  - Winner's slave_sel < NUM_SLAVES: go to GRANTn, latch `tgt` = slave_sel, set `last` = n.
  - Winner's slave_sel ≥ NUM_SLAVES: pulse `sel_err`, stay in IDLE, no grant, and set `last` = n so the other master wins the next tie.
- **GRANTn:**
  - `mn_grant` = 1, `bus_busy` = 1, `bus_sel` = n-1.
  - `s_valid[tgt]` = `mn_valid` (combinational); all other `s_valid` bits are 0.
  - `mn_ready` = `s_ready[tgt]` (combinational); the other master's ready is 0.
  - `mn_req` low: go to HANDOVER.
- **HANDOVER:** exactly one cycle with all grants 0 and `s_valid` = 0, then IDLE. This guarantees one dead cycle on the serial lines between owners.
- **Non-granted masters:** their valid is ignored and their ready is 0.
- **slave_sel changes during a grant:** ignored; `tgt` is held until HANDOVER.
- **`bus_sel` outside a grant:** holds its last value; it is meaningless when `bus_busy` = 0.
- **Reset (mid-transaction included):**
  - State → IDLE, `tgt` → 0, `last` → M2.
  - All grants, readies, `s_valid`, `bus_busy`, `sel_err`, `timeout` → 0, and `bus_sel` → 0.
  - A slave part-way through a frame is recovered by its own reset.

## Timing
- req rise to grant: 1 cycle when IDLE (req sampled at edge k, grant high after edge k).
- Grant to `s_valid`: 0 cycles (combinational through the latched `tgt`).
- req fall to grant low: 1 cycle. One more HANDOVER cycle, then the earliest new grant one cycle after that.
- Back-to-back handover: 3 cycles from the last owner's req fall to the next owner's grant.
- A master re-raising req in HANDOVER competes normally; round-robin hands the bus to the waiting other master first.
- Master protocol: a master asserts valid only after seeing its grant. Valid asserted before the grant is dropped.

## Configuration
- Macro: `BUS_ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter clears on entering GRANTn and increments each GRANT cycle.
  - When the counter reaches `TIMEOUT_CYCLES` while req is still high, the FSM forces HANDOVER and pulses `timeout` for one cycle.
  - The revoked master's req is then masked until it drops low at least once (tracked by a per-master `lockout` bit, cleared by reset).
- **Undefined:** no counter or lockout logic; `timeout` is tied 0 and grants last until req falls.

## Structure
- Shared package/header `bus_pkg`:
  - State encodings (IDLE = 0, GRANT1 = 1, GRANT2 = 2, HANDOVER = 3).
  - `SLAVE_ID_W` = 2, `ADDR_W` = 12, `DATA_W` = 8 (shared with the slave in-port).
- One sub-module, `arb_rr_pick`: a combinational round-robin winner select from (req1, req2, last), outputting winner_valid and winner_id.
- Routing muxes and the FSM stay in the top module.

## Test plan
- **Single M1 to slave 2:** `m1_req` = 1, `m1_slave_sel` = 2 → `m1_grant` next cycle, `bus_sel` = 0. `m1_valid` = 1 → `s_valid` = 3'b100 the same cycle. `s_ready[2]` = 1 → `m1_ready` = 1.
- **Tie after reset:** both req = 1 → M1 granted first. M1 drops req → grant low, one HANDOVER cycle, then `m2_grant` with `bus_sel` = 1, exactly 3 cycles after M1's req fall.
- **Invalid target:** `m2_slave_sel` = 3 with `m2_req` = 1 → `sel_err` pulses one cycle, no grant, `s_valid` stays 0. With both requesting the next cycle, M1 wins.
- **slave_sel changed mid-grant:** M1 granted to slave 0, `m1_slave_sel` changed to 1 → `s_valid` stays routed to slave 0 until release.
- **Reset mid-grant:** reset during GRANT2 → next cycle all outputs 0 and state IDLE. With both req then high, M1 wins.
- **Timeout (`BUS_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4):** M1 holds req → `timeout` pulse and grant drop after 4 grant cycles. M1 stays ungranted until its req toggles low then high.
